// File: rtl/serial_adder_nb.sv
// Multi-cycle ripple adder: adds DIGIT bits per clock behind valid/ready handshakes.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_nb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             ovf,
    output logic             err
);

    // Clamped slice width keeps illegal builds elaborating; err flags them.
    localparam int unsigned DW    = (DIGIT == 0) ? 1 : ((DIGIT > WIDTH) ? WIDTH : DIGIT);
    localparam int unsigned STEPS = WIDTH / DW;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam bit ERR = (DIGIT == 0) || (DIGIT > WIDTH) || ((WIDTH % DW) != 0);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_shift;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, c_out_q, ovf_q;
    logic             in_ready_q, out_valid_q;
    logic [DW:0]      slice;
    logic             msb_cin;
    logic             sub_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_bit = sub;
`else
    assign sub_bit = 1'b0;
`endif

    assign slice = {1'b0, a_q[DW-1:0]} + {1'b0, b_q[DW-1:0]} + {{DW{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from its sum bit.
    assign msb_cin = a_q[DW-1] ^ b_q[DW-1] ^ slice[DW-1];

    always_comb begin
        s_shift = s_q >> DW;
        s_shift[WIDTH-1 -: DW] = slice[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= sub_bit ? ~B : B;
                        carry_q    <= C_in ^ sub_bit;
                        cnt_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                    end
                end
                StRun: begin
                    s_q     <= s_shift;
                    a_q     <= a_q >> DW;
                    b_q     <= b_q >> DW;
                    carry_q <= slice[DW];
                    if (cnt_q == LAST) begin
                        c_out_q     <= slice[DW];
                        ovf_q       <= msb_cin ^ slice[DW];
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign C_out     = c_out_q;
    assign ovf       = ovf_q;
    assign err       = ERR;

endmodule

// File: tb/tb_serial_adder_nb.sv
// Scoreboard bench for serial_adder_nb: three legal configurations share one stimulus
// bus (selected by sel) plus an illegal WIDTH=10/DIGIT=4 build for err.
module tb_serial_adder_nb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        C_in = 1'b0;
    logic        sub = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic [2:0]  iv, rdy, ov, co, of, er;
    logic [15:0] s_w [3];
    logic [9:0]  bad_s;
    logic        bad_rdy, bad_ov, bad_co, bad_of, bad_err;

    logic        cur_in_ready, cur_out_valid, cur_c, cur_ovf;
    logic [15:0] cur_s;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [17:0] exp_q [$];

    always #5 clk = ~clk;

    assign iv[0] = in_valid && (sel == 2'd0);
    assign iv[1] = in_valid && (sel == 2'd1);
    assign iv[2] = in_valid && (sel == 2'd2);

    serial_adder_nb #(.WIDTH(16), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .A(A), .B(B), .C_in(C_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[0]), .out_ready(out_ready), .S(s_w[0]), .C_out(co[0]),
        .ovf(of[0]), .err(er[0])
    );

    serial_adder_nb #(.WIDTH(16), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .A(A), .B(B), .C_in(C_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[1]), .out_ready(out_ready), .S(s_w[1]), .C_out(co[1]),
        .ovf(of[1]), .err(er[1])
    );

    serial_adder_nb #(.WIDTH(16), .DIGIT(16)) dut_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .A(A), .B(B), .C_in(C_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[2]), .out_ready(out_ready), .S(s_w[2]), .C_out(co[2]),
        .ovf(of[2]), .err(er[2])
    );

    serial_adder_nb #(.WIDTH(10), .DIGIT(4)) dut_bad (
        .clk(clk), .rst_n(rst_n), .in_valid(1'b0), .in_ready(bad_rdy),
        .A(A[9:0]), .B(B[9:0]), .C_in(1'b0),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(bad_ov), .out_ready(1'b1), .S(bad_s), .C_out(bad_co),
        .ovf(bad_of), .err(bad_err)
    );

    always_comb begin
        cur_in_ready  = rdy[sel];
        cur_out_valid = ov[sel];
        cur_s         = s_w[sel];
        cur_c         = co[sel];
        cur_ovf       = of[sel];
    end

    function automatic int steps_of(input logic [1:0] k);
        return (k == 2'd0) ? 16 : ((k == 2'd1) ? 4 : 1);
    endfunction

    // Returns {ovf, C_out, S} from plain wide arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        logic [15:0] bb;
        logic [16:0] sum;
        logic        v;
        bb  = sb ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {16'd0, ci ^ sb};
        v   = (a[15] == bb[15]) && (sum[15] != a[15]);
        return {v, sum[16], sum[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb);
        int   n = 0;
        logic sbe;
`ifdef SERIAL_ADDER_SUB_EN
        sbe = sb;
`else
        sbe = 1'b0;
`endif
        while (!cur_in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cur_in_ready) check("in_ready_wait", {31'd0, cur_in_ready}, 32'd1);
        A = a;
        B = b;
        C_in = ci;
        sub = sbe;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(model(a, b, ci, sbe));
    endtask

    // Waits for out_valid, checks latency and result; does not perform the handshake.
    task automatic collect(input string tag);
        int          n = 0;
        logic [17:0] e;
        while (!cur_out_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, steps_of(sel));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_s"}, {16'd0, cur_s}, {16'd0, e[15:0]});
            check({tag, "_cout"}, {31'd0, cur_c}, {31'd0, e[16]});
            check({tag, "_ovf"}, {31'd0, cur_ovf}, {31'd0, e[17]});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {31'd0, cur_in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, cur_out_valid}, 32'd0);
        check({tag, "_s"}, {16'd0, cur_s}, 32'd0);
        check({tag, "_cout"}, {31'd0, cur_c}, 32'd0);
        check({tag, "_ovf"}, {31'd0, cur_ovf}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sel = 2'd0;
        check_reset_vals("rst");
        check("err_legal", {31'd0, er[0]}, 32'd0);
        check("err_illegal", {31'd0, bad_err}, 32'd1);

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        collect("carry");
        tick();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        collect("ovf");
        check("ovf_s", {16'd0, cur_s}, 32'h8000);
        check("ovf_flag", {31'd0, cur_ovf}, 32'd1);
        tick();
        check("hold_s_idle", {16'd0, cur_s}, 32'h8000);

        // Asynchronous reset pulse in the middle of a cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        tick();
        rst_n = 1'b1;

        sel = 2'd1;
        send(16'h1234, 16'h0FCD, 1'b1, 1'b0);
        collect("basic");
        check("basic_s", {16'd0, cur_s}, 32'h2202);
        tick();
        check("basic_after_hs", {30'd0, cur_out_valid, cur_in_ready}, 32'd1);

        for (int k = 0; k < 3; k++) begin
            sel = k[1:0];
            for (int j = 0; j < 6; j++) begin
                send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                collect("rand");
                tick();
            end
        end
        sel = 2'd2;
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        collect("d16_max");
        tick();

        // Backpressure: result must hold while in_valid toggles.
        sel = 2'd1;
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        collect("bp");
        for (int i = 0; i < 5; i++) begin
            A = 16'($urandom);
            B = 16'($urandom);
            in_valid = (i % 2 == 0);
            tick();
            check("bp_hold_s", {16'd0, cur_s}, 32'h3333);
            check("bp_hold_ready_valid", {30'd0, cur_out_valid, cur_in_ready}, 32'd2);
        end
        A = 16'h0102;
        B = 16'h0304;
        C_in = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        check("bp_release", {30'd0, cur_out_valid, cur_in_ready}, 32'd1);
        exp_q.push_back(model(16'h0102, 16'h0304, 1'b0, 1'b0));
        tick();
        in_valid = 1'b0;
        collect("bp_next");
        tick();

        // Reset six cycles into a run: operation abandoned.
        sel = 2'd0;
        send(16'h00F0, 16'h0F00, 1'b0, 1'b0);
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("run_rst");
        void'(exp_q.pop_back());
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cur_out_valid) seen++;
        end
        check("run_rst_no_output", seen, 0);
        send(16'd3, 16'd4, 1'b0, 1'b0);
        collect("after_rst");
        check("after_rst_s", {16'd0, cur_s}, 32'd7);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        collect("sub");
        check("sub_s", {16'd0, cur_s}, 32'hFFFE);
        check("sub_cout", {31'd0, cur_c}, 32'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
